// File: rtl/blast_scan_ctrl.sv
// Flame propagation sequencer: arbitrates two bomb requesters, walks the four
// directions from the bomb centre against the wall map and streams flame tiles.
module blast_scan_ctrl #(
  parameter int MAP_DIM = 12,
  parameter int COORD_W = 4,
  parameter int RANGE_W = 3
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [MAP_DIM*MAP_DIM-1:0]   Wall_Map_In,
  input  logic [1:0]                   Req,
  input  logic [COORD_W-1:0]           Req_Row0,
  input  logic [COORD_W-1:0]           Req_Col0,
  input  logic [RANGE_W-1:0]           Req_Range0,
  input  logic [COORD_W-1:0]           Req_Row1,
  input  logic [COORD_W-1:0]           Req_Col1,
  input  logic [RANGE_W-1:0]           Req_Range1,
  output logic [1:0]                   Grant,
  output logic                         Busy,
  output logic                         Flame_Valid,
  input  logic                         Flame_Ready,
  output logic [COORD_W-1:0]           Flame_Row,
  output logic [COORD_W-1:0]           Flame_Col,
  output logic                         Done
);

  localparam int IDX_W = $clog2(MAP_DIM*MAP_DIM);
  localparam logic signed [COORD_W:0] MAX_C     = (COORD_W+1)'(MAP_DIM-1);
  localparam logic [RANGE_W:0]        STEP_ONE  = (RANGE_W+1)'(1);
  localparam logic [IDX_W-1:0]        LAST_BIT  = IDX_W'(MAP_DIM*MAP_DIM-1);

  typedef enum logic [1:0] {S_IDLE, S_CENTER, S_SCAN, S_DONE} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t               r_state;
  dir_t                 r_dir;
  logic [RANGE_W:0]     r_step;
  logic                 r_prio;
  logic [COORD_W-1:0]   r_row;
  logic [COORD_W-1:0]   r_col;
  logic [RANGE_W-1:0]   r_range;

  logic                      w_win1;
  logic [COORD_W-1:0]        w_win_row;
  logic [COORD_W-1:0]        w_win_col;
  logic [RANGE_W-1:0]        w_win_range;
  logic signed [COORD_W:0]   w_step_s;
  logic signed [COORD_W:0]   w_row_s;
  logic signed [COORD_W:0]   w_col_s;
  logic signed [COORD_W:0]   w_cand_row;
  logic signed [COORD_W:0]   w_cand_col;
  logic                      w_on_map;
  logic [IDX_W-1:0]          w_lin;
  logic                      w_wall;
  logic                      w_end;

  // r_prio = 1 means requester 1 wins a tie
  assign w_win1      = Req[1] & (~Req[0] | r_prio);
  assign w_win_row   = w_win1 ? Req_Row1   : Req_Row0;
  assign w_win_col   = w_win1 ? Req_Col1   : Req_Col0;
  assign w_win_range = w_win1 ? Req_Range1 : Req_Range0;

  assign w_step_s = signed'((COORD_W+1)'(r_step));
  assign w_row_s  = signed'({1'b0, r_row});
  assign w_col_s  = signed'({1'b0, r_col});

  always_comb begin
    w_cand_row = w_row_s;
    w_cand_col = w_col_s;
    case (r_dir)
      D_UP:    w_cand_row = w_row_s - w_step_s;
      D_DOWN:  w_cand_row = w_row_s + w_step_s;
      D_LEFT:  w_cand_col = w_col_s - w_step_s;
      default: w_cand_col = w_col_s + w_step_s;
    endcase
  end

  // The sign bit catches both negative candidates and any overflow past the top
  assign w_on_map = ~w_cand_row[COORD_W] && (w_cand_row <= MAX_C) &&
                    ~w_cand_col[COORD_W] && (w_cand_col <= MAX_C);
  assign w_lin    = w_on_map ? (IDX_W'(w_cand_row[COORD_W-1:0]) * IDX_W'(MAP_DIM) +
                                IDX_W'(w_cand_col[COORD_W-1:0])) : '0;
  assign w_wall   = w_on_map & Wall_Map_In[LAST_BIT - w_lin];
  assign w_end    = (r_step > {1'b0, r_range}) | ~w_on_map | w_wall;

  always_ff @(posedge Clk) begin
    if (r_state == S_IDLE && |Req) begin
      r_row   <= w_win_row;
      r_col   <= w_win_col;
      r_range <= w_win_range;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_dir       <= D_UP;
      r_step      <= STEP_ONE;
      r_prio      <= 1'b0;
      Grant       <= 2'b00;
      Busy        <= 1'b0;
      Flame_Valid <= 1'b0;
      Flame_Row   <= '0;
      Flame_Col   <= '0;
      Done        <= 1'b0;
    end else begin
      Grant <= 2'b00;
      Done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|Req) begin
            Grant       <= w_win1 ? 2'b10 : 2'b01;
            r_prio      <= ~w_win1;
            Busy        <= 1'b1;
            Flame_Valid <= 1'b1;
            Flame_Row   <= w_win_row;
            Flame_Col   <= w_win_col;
            r_state     <= S_CENTER;
          end
        end
        S_CENTER: begin
          if (Flame_Ready) begin
            Flame_Valid <= 1'b0;
            r_dir       <= D_UP;
            r_step      <= STEP_ONE;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (Flame_Valid) begin
            if (Flame_Ready) begin
              Flame_Valid <= 1'b0;
              r_step      <= r_step + STEP_ONE;
            end
          end else if (w_end) begin
            r_step <= STEP_ONE;
            if (r_dir == D_RIGHT) begin
              Done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dir <= dir_t'(r_dir + 2'd1);
            end
          end else begin
            Flame_Valid <= 1'b1;
            Flame_Row   <= w_cand_row[COORD_W-1:0];
            Flame_Col   <= w_cand_col[COORD_W-1:0];
          end
        end
        S_DONE: begin
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
